// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with MEM/WB forwarding, ALU operand
// selection and load-use hazard detection.
module ex_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_d,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic [XLEN-1:0]       rs1_data_d,
  input  logic [XLEN-1:0]       rs2_data_d,
  input  logic [XLEN-1:0]       imm_d,
  input  logic [XLEN-1:0]       pc_d,
  input  logic [3:0]            alu_control_d,
  input  logic [1:0]            alu_src_a_d,
  input  logic                  alu_src_b_d,
  input  logic                  reg_write_d,
  input  logic                  mem_read_d,
  input  logic                  stall_e,
  input  logic                  flush_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  reg_write_m,
  input  logic [XLEN-1:0]       alu_result_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_w,
  input  logic [XLEN-1:0]       result_w,
  output logic [XLEN-1:0]       src_a_e,
  output logic [XLEN-1:0]       src_b_e,
  output logic [3:0]            alu_control_e,
  output logic [XLEN-1:0]       write_data_e,
  output logic [REG_ADDR_W-1:0] rd_e,
  output logic                  reg_write_e,
  output logic                  mem_read_e,
  output logic [XLEN-1:0]       pc_e,
  output logic                  valid_e,
  output logic                  load_use_stall
);
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       pc;
    logic [3:0]            alu_control;
    logic [1:0]            alu_src_a;
    logic                  alu_src_b;
    logic                  reg_write;
    logic                  mem_read;
  } ex_t;
  ex_t ex_d, ex_q, cap;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  always_comb begin
    cap             = '0;
    cap.valid       = valid_d;
    cap.rs1         = rs1_d;
    cap.rs2         = rs2_d;
    cap.rd          = rd_d;
    cap.rs1_data    = rs1_data_d;
    cap.rs2_data    = rs2_data_d;
    cap.imm         = imm_d;
    cap.pc          = pc_d;
    cap.alu_control = alu_control_d;
    cap.alu_src_a   = alu_src_a_d;
    cap.alu_src_b   = alu_src_b_d;
    cap.reg_write   = reg_write_d & valid_d;
    cap.mem_read    = mem_read_d & valid_d;
    ex_d            = flush_e ? '0 : stall_e ? ex_q : cap;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  // MEM beats WB; x0 is hardwired so it is never forwarded
  always_comb begin
    fwd_rs1 = (reg_write_m && rd_m != '0 && rd_m == ex_q.rs1) ? alu_result_m :
              (reg_write_w && rd_w != '0 && rd_w == ex_q.rs1) ? result_w : ex_q.rs1_data;
    fwd_rs2 = (reg_write_m && rd_m != '0 && rd_m == ex_q.rs2) ? alu_result_m :
              (reg_write_w && rd_w != '0 && rd_w == ex_q.rs2) ? result_w : ex_q.rs2_data;
  end
  assign src_a_e        = ex_q.alu_src_a == 2'b00 ? fwd_rs1 :
                          ex_q.alu_src_a == 2'b01 ? ex_q.pc : '0;
  assign src_b_e        = ex_q.alu_src_b ? ex_q.imm : fwd_rs2;
  assign write_data_e   = fwd_rs2;
  assign alu_control_e  = ex_q.alu_control;
  assign rd_e           = ex_q.rd;
  assign reg_write_e    = ex_q.reg_write;
  assign mem_read_e     = ex_q.mem_read;
  assign pc_e           = ex_q.pc;
  assign valid_e        = ex_q.valid;
  assign load_use_stall = ex_q.mem_read && ex_q.valid && ex_q.rd != '0 && valid_d &&
                          (ex_q.rd == rs1_d || ex_q.rd == rs2_d);
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: random stimulus checked every cycle against a behavioural
// model of the EX operand stage, plus directed literal checks.
module tb_ex_operand_stage;
  logic        clk = 0, reset = 1;
  logic        valid_d = 0, alu_src_b_d = 0, reg_write_d = 0, mem_read_d = 0;
  logic        stall_e = 0, flush_e = 0, reg_write_m = 0, reg_write_w = 0;
  logic [4:0]  rs1_d = 0, rs2_d = 0, rd_d = 0, rd_m = 0, rd_w = 0;
  logic [31:0] rs1_data_d = 0, rs2_data_d = 0, imm_d = 0, pc_d = 0, alu_result_m = 0, result_w = 0;
  logic [3:0]  alu_control_d = 0;
  logic [1:0]  alu_src_a_d = 0;
  logic [31:0] src_a_e, src_b_e, write_data_e, pc_e;
  logic [3:0]  alu_control_e;
  logic [4:0]  rd_e;
  logic        reg_write_e, mem_read_e, valid_e, load_use_stall;
  int checks = 0, errors = 0;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .rs1_data_d(rs1_data_d), .rs2_data_d(rs2_data_d), .imm_d(imm_d), .pc_d(pc_d),
    .alu_control_d(alu_control_d), .alu_src_a_d(alu_src_a_d), .alu_src_b_d(alu_src_b_d),
    .reg_write_d(reg_write_d), .mem_read_d(mem_read_d), .stall_e(stall_e), .flush_e(flush_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .alu_result_m(alu_result_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .result_w(result_w),
    .src_a_e(src_a_e), .src_b_e(src_b_e), .alu_control_e(alu_control_e),
    .write_data_e(write_data_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
    .mem_read_e(mem_read_e), .pc_e(pc_e), .valid_e(valid_e), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  // Model: the instruction currently held in EX
  logic        m_valid, m_sb, m_rw, m_mr;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_d1, m_d2, m_imm, m_pc;
  logic [3:0]  m_op;
  logic [1:0]  m_sa;

  task automatic m_clear();
    {m_valid, m_sb, m_rw, m_mr, m_rs1, m_rs2, m_rd, m_d1, m_d2, m_imm, m_pc, m_op, m_sa} = '0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset || flush_e) m_clear();
    else if (!stall_e) begin
      m_valid = valid_d; m_rs1 = rs1_d; m_rs2 = rs2_d; m_rd = rd_d;
      m_d1 = rs1_data_d; m_d2 = rs2_data_d; m_imm = imm_d; m_pc = pc_d;
      m_op = alu_control_d; m_sa = alu_src_a_d; m_sb = alu_src_b_d;
      m_rw = reg_write_d && valid_d; m_mr = mem_read_d && valid_d;
    end
  end

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] reg_val);
    if (idx == 0) return reg_val;
    if (reg_write_m && rd_m == idx) return alu_result_m;
    if (reg_write_w && rd_w == idx) return result_w;
    return reg_val;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (!reset) begin
    logic [31:0] ea, eb, wd;
    wd = fwd(m_rs2, m_d2);
    ea = m_sa == 2'd0 ? fwd(m_rs1, m_d1) : m_sa == 2'd1 ? m_pc : 32'd0;
    eb = m_sb ? m_imm : wd;
    cmp("src_a", src_a_e, ea);
    cmp("src_b", src_b_e, eb);
    cmp("write_data", write_data_e, wd);
    cmp("alu_control", {28'd0, alu_control_e}, {28'd0, m_op});
    cmp("rd", {27'd0, rd_e}, {27'd0, m_rd});
    cmp("pc", pc_e, m_pc);
    cmp("flags", {28'd0, valid_e, reg_write_e, mem_read_e, load_use_stall},
        {28'd0, m_valid, m_rw, m_mr,
         m_mr && m_valid && m_rd != 0 && valid_d && (m_rd == rs1_d || m_rd == rs2_d)});
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rand_inputs();
    valid_d = $urandom_range(0, 3) != 0;
    rs1_d = 5'($urandom_range(0, 7)); rs2_d = 5'($urandom_range(0, 7)); rd_d = 5'($urandom_range(0, 7));
    rs1_data_d = $urandom; rs2_data_d = $urandom; imm_d = $urandom; pc_d = $urandom;
    alu_control_d = 4'($urandom); alu_src_a_d = 2'($urandom); alu_src_b_d = 1'($urandom);
    reg_write_d = 1'($urandom); mem_read_d = $urandom_range(0, 2) == 0;
    stall_e = $urandom_range(0, 7) == 0; flush_e = $urandom_range(0, 9) == 0;
    rd_m = 5'($urandom_range(0, 7)); rd_w = 5'($urandom_range(0, 7));
    reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
    alu_result_m = $urandom; result_w = $urandom;
  endtask

  initial begin
    tick(); tick();
    cmp("reset_valid", {31'd0, valid_e}, 32'd0);
    cmp("reset_src_a", src_a_e, 32'd0);
    reset = 0;
    // basic capture
    valid_d = 1; rs1_d = 1; rs1_data_d = 5; imm_d = 7; alu_src_b_d = 1; alu_control_d = 0;
    tick();
    cmp("cap_src_a", src_a_e, 32'd5);
    cmp("cap_src_b", src_b_e, 32'd7);
    cmp("cap_alu_control", {28'd0, alu_control_e}, 32'd0);
    // forwarding priority
    rs1_d = 3; rs1_data_d = 32'h11;
    tick();
    rd_m = 3; rd_w = 3; reg_write_m = 1; reg_write_w = 1; alu_result_m = 32'hAA; result_w = 32'hBB;
    #1 cmp("fwd_mem", src_a_e, 32'hAA);
    reg_write_m = 0;
    #1 cmp("fwd_wb", src_a_e, 32'hBB);
    reg_write_w = 0;
    // x0 guard
    rs2_d = 0; rs2_data_d = 0; alu_src_b_d = 0;
    tick();
    rd_m = 0; reg_write_m = 1; alu_result_m = 32'h55;
    #1 cmp("x0_src_b", src_b_e, 32'd0);
    cmp("x0_write_data", write_data_e, 32'd0);
    reg_write_m = 0;
    // stall then flush
    alu_control_d = 4'h5; rd_d = 7; reg_write_d = 1;
    tick();
    stall_e = 1; alu_control_d = 4'h9; rd_d = 2;
    tick(); alu_control_d = 4'hC; rd_d = 1; tick();
    cmp("stall_alu_control", {28'd0, alu_control_e}, 32'h5);
    cmp("stall_rd", {27'd0, rd_e}, 32'd7);
    cmp("stall_reg_write", {31'd0, reg_write_e}, 32'd1);
    flush_e = 1;
    tick();
    cmp("flush_valid", {31'd0, valid_e}, 32'd0);
    cmp("flush_reg_write", {31'd0, reg_write_e}, 32'd0);
    stall_e = 0; flush_e = 0; reg_write_d = 0;
    // load-use
    mem_read_d = 1; rd_d = 4;
    tick();
    mem_read_d = 0; rs1_d = 9; rs2_d = 4;
    #1 cmp("load_use_hit", {31'd0, load_use_stall}, 32'd1);
    mem_read_d = 1; rd_d = 0;
    tick();
    rs1_d = 0; rs2_d = 0;
    #1 cmp("load_use_x0", {31'd0, load_use_stall}, 32'd0);
    // async reset mid-cycle
    mem_read_d = 0; alu_control_d = 4'h6; rs1_d = 2; rs1_data_d = 32'h1234; imm_d = 32'h99; alu_src_b_d = 1;
    tick();
    cmp("pre_reset_valid", {31'd0, valid_e}, 32'd1);
    #2 reset = 1;
    #1 cmp("async_valid", {31'd0, valid_e}, 32'd0);
    cmp("async_alu_control", {28'd0, alu_control_e}, 32'd0);
    cmp("async_src_a", src_a_e, 32'd0);
    cmp("async_src_b", src_b_e, 32'd0);
    tick(); reset = 0;
    repeat (3000) begin
      rand_inputs();
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus execute-stage operand selection; sits directly upstream of the ALU.
- Latches decoded instruction fields and register-file read data each cycle.
- Applies MEM/WB forwarding and source muxing, then drives the ALU's a, b and alu_control inputs.
- Detects load-use hazards and requests a decode stall.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register index width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
valid_d  input  1  decode slot holds a real instruction
rs1_d  input  5  source register 1 index
rs2_d  input  5  source register 2 index
rd_d  input  5  destination index
rs1_data_d  input  32  register-file read, port 1
rs2_data_d  input  32  register-file read, port 2
imm_d  input  32  sign-extended immediate
pc_d  input  32  instruction PC
alu_control_d  input  4  ALU op code, same encoding as ALU
alu_src_a_d  input  2  00 reg rs1, 01 PC, 10 zero, 11 reserved (treated as zero)
alu_src_b_d  input  1  0 reg rs2, 1 immediate
reg_write_d  input  1  instruction writes rd
mem_read_d  input  1  instruction is a load
stall_e  input  1  hold EX register contents
flush_e  input  1  insert bubble into EX
rd_m, reg_write_m, alu_result_m  input  5/1/32  MEM-stage forwarding source
rd_w, reg_write_w, result_w  input  5/1/32  WB-stage forwarding source
src_a_e  output  32  ALU operand a
src_b_e  output  32  ALU operand b
alu_control_e  output  4  ALU control
write_data_e  output  32  forwarded rs2 value (store data)
rd_e  output  5  registered destination
reg_write_e  output  1  registered write enable, gated by valid
mem_read_e  output  1  registered load flag, gated by valid
pc_e  output  32  registered PC
valid_e  output  1  EX slot valid
load_use_stall  output  1  request stall of fetch/decode

Behaviour:
Register update, at rising clk:
- Priority is reset > flush_e > stall_e > load.
- reset (async, any time, including mid-stall): all registered fields clear to 0.
  - alu_control_e = 0000 (ADD), src_a_e = 0, src_b_e = 0, valid_e = 0, load_use_stall = 0.
- flush_e = 1: the following are cleared.
  - valid_e, reg_write_e, mem_read_e, rd_e cleared.
  - alu_control_e cleared to 0000.
  - Other fields don't-care; they are cleared to 0 for determinism.
- flush_e and stall_e together: flush wins.
- stall_e = 1 (no flush): all registers hold.
- Otherwise all fields load from the *_d inputs.
- Registered reg_write and mem_read are ANDed with valid_d.

Forwarding (combinational, computed on the registered rs1/rs2):
- fwd_x = MEM when reg_write_m && rd_m != 0 && rd_m == rs_x_e.
- Else WB when reg_write_w && rd_w != 0 && rd_w == rs_x_e.
- Else the registered register-file data.
- MEM has priority over WB. x0 is never forwarded.

Operand selection:
- src_a_e = forwarded rs1 / pc_e / 0, per registered alu_src_a.
- src_b_e = forwarded rs2 or registered imm, per registered alu_src_b.
- write_data_e is always forwarded rs2, regardless of alu_src_b.
- Latency: decode inputs appear on the ALU operands 1 cycle after capture. Forwarding adds no cycles.

Load-use stall (combinational):
- load_use_stall = mem_read_e && valid_e && rd_e != 0 && valid_d && (rd_e == rs1_d || rd_e == rs2_d).
- The hazard unit responds with stall of decode plus flush_e next edge. This block does not self-flush.

Test Plan:
- Reset mid-operation: assert reset asynchronously between edges with valid_e = 1 -> immediately valid_e = 0, alu_control_e = 0000, src_a_e = src_b_e = 0.
- Basic capture: rs1_data_d = 5, imm_d = 7, alu_src_b_d = 1, alu_control_d = 0000 -> next cycle src_a_e = 5, src_b_e = 7, alu_control_e = 0000.
- Forward priority: rs1_e = 3, rd_m = rd_w = 3, both write, alu_result_m = 0xAA, result_w = 0xBB -> src_a_e = 0xAA. Drop reg_write_m -> src_a_e = 0xBB.
- x0 guard: rs2_e = 0, rd_m = 0, reg_write_m = 1, alu_result_m = 0x55, rs2 reg data = 0 -> src_b_e = 0 and write_data_e = 0.
- Stall/flush: stall_e = 1 for 2 cycles with changing *_d -> outputs hold. Then flush_e = stall_e = 1 -> valid_e = 0, reg_write_e = 0.
- Load-use: EX holds a load with rd_e = 4, decode has rs2_d = 4, valid_d = 1 -> load_use_stall = 1. Same setup with rd_e = 0 -> load_use_stall = 0.
